tap_sequencer: RTL

TAP_SEQUENCER -- requirements
Module: tap_sequencer

---
 rtl/tap_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/tap_sequencer.sv
// Tap sequencer: stores each ADC sample into a circular buffer region, then fetches
// num_taps delayed taps spaced tap_spacing apart, with one outstanding read at a time.
module tap_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic [15:0] sample_in,
    input  logic        enable,
    input  logic [7:0]  num_taps,
    input  logic [15:0] tap_spacing,
    input  logic [15:0] buf_base,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        tap_valid,
    output logic [15:0] tap_data,
    output logic [7:0]  tap_index,
    output logic        frame_done,
    output logic        overrun,
    output logic        config_err
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdIssue,
        StRdWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] wr_ptr_q, wr_ptr_d;
    logic [15:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] sample_q, sample_d;
    logic [15:0] spacing_q, spacing_d;
    logic [15:0] base_q, base_d;
    logic [7:0]  taps_q, taps_d;
    logic [7:0]  tap_cnt_q, tap_cnt_d;
    logic        overrun_q, overrun_d;
    logic        cfg_err_q, cfg_err_d;
    logic        tap_valid_q, tap_valid_d;
    logic [15:0] tap_data_q, tap_data_d;
    logic [7:0]  tap_index_q, tap_index_d;

    logic [15:0] in_len;
    logic        in_cfg_bad;
    logic        idle_like;
    logic        frame_start;
    logic [15:0] frame_len;
    logic [16:0] rd_diff;
    logic [15:0] rd_next;

    assign in_len      = 16'hFFFF - buf_base;
    assign in_cfg_bad  = (buf_base == 16'hFFFF) ||
                         ((num_taps != 8'd0) && (tap_spacing >= in_len));
    assign idle_like   = (state_q == StIdle) || (state_q == StDone);
    assign frame_start = idle_like && enable && sample_tick;

    // Next tap address: step back by the spacing, folding into the region on a borrow
    // or when the result falls below the region base.
    assign frame_len = 16'hFFFF - base_q;
    assign rd_diff   = {1'b0, rd_ptr_q} - {1'b0, spacing_q};
    assign rd_next   = (rd_diff[16] || (rd_diff[15:0] < base_q)) ?
                       (rd_diff[15:0] + frame_len) : rd_diff[15:0];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sample_d    = sample_q;
        spacing_d   = spacing_q;
        base_d      = base_q;
        taps_d      = taps_q;
        tap_cnt_d   = tap_cnt_q;
        overrun_d   = overrun_q;
        cfg_err_d   = cfg_err_q;
        tap_valid_d = 1'b0;
        tap_data_d  = tap_data_q;
        tap_index_d = tap_index_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 16'h0000;
        mem_wdata   = 16'h0000;
        frame_done  = 1'b0;

        // Ticks arriving while a frame is in flight are dropped but remembered.
        if (sample_tick && !idle_like) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                frame_done = (state_q == StDone);
                if (!enable) begin
                    overrun_d = 1'b0;
                    cfg_err_d = 1'b0;
                end
                if (frame_start) begin
                    sample_d  = sample_in;
                    spacing_d = tap_spacing;
                    base_d    = buf_base;
                    taps_d    = num_taps;
                    cfg_err_d = in_cfg_bad;
                    if ((wr_ptr_q < buf_base) || (wr_ptr_q == 16'hFFFF)) begin
                        wr_ptr_d = buf_base;
                    end
                    state_d = StWrite;
                end else begin
                    state_d = StIdle;
                end
            end

            StWrite: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_ptr_q;
                mem_wdata = sample_q;
                if (mem_ready) begin
                    rd_ptr_d  = wr_ptr_q;
                    wr_ptr_d  = (wr_ptr_q == 16'hFFFE) ? base_q : (wr_ptr_q + 16'd1);
                    tap_cnt_d = 8'd0;
                    state_d   = ((taps_q != 8'd0) && !cfg_err_q) ? StRdIssue : StDone;
                end
            end

            StRdIssue: begin
                mem_req  = 1'b1;
                mem_addr = rd_next;
                if (mem_ready) begin
                    rd_ptr_d = rd_next;
                    state_d  = StRdWait;
                end
            end

            StRdWait: begin
                if (mem_rvalid) begin
                    tap_data_d  = mem_rdata;
                    tap_index_d = tap_cnt_q;
                    tap_valid_d = 1'b1;
                    tap_cnt_d   = tap_cnt_q + 8'd1;
                    state_d     = ((tap_cnt_q + 8'd1) != taps_q) ? StRdIssue : StDone;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= 16'h0000;
            rd_ptr_q    <= 16'h0000;
            sample_q    <= 16'h0000;
            spacing_q   <= 16'h0000;
            base_q      <= 16'h0000;
            taps_q      <= 8'd0;
            tap_cnt_q   <= 8'd0;
            overrun_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            tap_valid_q <= 1'b0;
            tap_data_q  <= 16'h0000;
            tap_index_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sample_q    <= sample_d;
            spacing_q   <= spacing_d;
            base_q      <= base_d;
            taps_q      <= taps_d;
            tap_cnt_q   <= tap_cnt_d;
            overrun_q   <= overrun_d;
            cfg_err_q   <= cfg_err_d;
            tap_valid_q <= tap_valid_d;
            tap_data_q  <= tap_data_d;
            tap_index_q <= tap_index_d;
        end
    end

    assign tap_valid  = tap_valid_q;
    assign tap_data   = tap_data_q;
    assign tap_index  = tap_index_q;
    assign overrun    = overrun_q;
    assign config_err = cfg_err_q;

endmodule
